// File: rtl/reset_seq_ctrl.sv
// rtl/reset_seq_ctrl.sv - ordered clock-enable / reset-release sequencer for N_DOM domains
//
// Power-up walks domains 0..N_DOM-1: ungate the clock, let it run PRE_CYC
// cycles, release reset, settle POST_CYC cycles, move on. Power-down walks
// N_DOM-1..0 in reverse: reassert reset, keep the clock running OFF_CYC
// cycles, gate it, move on. Because enables and releases only ever change
// one bit at a time in that order, release_rst_o is always a contiguous run
// from bit 0 and always a subset of clk_en_o.
module reset_seq_ctrl #(
  parameter int N_DOM    = 4,
  parameter int PRE_CYC  = 4,
  parameter int POST_CYC = 2,
  parameter int OFF_CYC  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_req_i,
  input  logic             down_req_i,
  output logic [N_DOM-1:0] clk_en_o,
  output logic [N_DOM-1:0] release_rst_o,
  output logic [2:0]       cur_dom_o,
  output logic             busy_o,
  output logic             all_up_o,
  output logic             all_down_o
);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    UP_PRE  = 3'd1,
    UP_POST = 3'd2,
    ON      = 3'd3,
    DN_RST  = 3'd4,
    DN_OFF  = 3'd5
  } state_t;

  localparam logic [2:0] LAST_DOM = 3'(N_DOM - 1);
  // Counter reload values: a state loaded with X-1 dwells exactly X cycles.
  localparam logic [3:0] PRE_LD   = 4'(PRE_CYC - 1);
  localparam logic [3:0] POST_LD  = 4'(POST_CYC - 1);
  localparam logic [3:0] OFF_LD   = 4'(OFF_CYC - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       dom_q, dom_d;
  logic [N_DOM-1:0] clk_en_q, clk_en_d;
  logic [N_DOM-1:0] rel_q, rel_d;
  logic             busy_q, busy_d;
  logic             all_up_q, all_up_d;
  logic             all_down_q, all_down_d;

  // One-hot mask selecting domain idx; built bitwise so N_DOM=1 needs no
  // narrow index arithmetic.
  function automatic logic [N_DOM-1:0] dom_bit(input logic [2:0] idx);
    logic [N_DOM-1:0] r;
    r = '0;
    for (int i = 0; i < N_DOM; i++) begin
      r[i] = (idx == 3'(i));
    end
    return r;
  endfunction

  // Next-state, dwell counter and next output values for the sequencer.
  always_comb begin
    state_d  = state_q;
    dom_d    = dom_q;
    clk_en_d = clk_en_q;
    rel_d    = rel_q;
    // Saturating count: parks at zero rather than wrapping.
    cnt_d    = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : 4'd0;

    unique case (state_q)
      OFF: begin
        // down_req_i has no meaning here; up wins a simultaneous request.
        if (up_req_i) begin
          state_d  = UP_PRE;
          dom_d    = 3'd0;
          clk_en_d = clk_en_q | dom_bit(3'd0);
          cnt_d    = PRE_LD;
        end
      end
      UP_PRE: begin
        if (cnt_q == 4'd0) begin
          state_d = UP_POST;
          rel_d   = rel_q | dom_bit(dom_q);
          cnt_d   = POST_LD;
        end
      end
      UP_POST: begin
        if (cnt_q == 4'd0) begin
          if (dom_q == LAST_DOM) begin
            state_d = ON;
            cnt_d   = 4'd0;
          end else begin
            state_d  = UP_PRE;
            dom_d    = dom_q + 3'd1;
            clk_en_d = clk_en_q | dom_bit(dom_q + 3'd1);
            cnt_d    = PRE_LD;
          end
        end
      end
      ON: begin
        // up_req_i has no meaning here; down wins a simultaneous request.
        if (down_req_i) begin
          state_d = DN_RST;
          dom_d   = LAST_DOM;
          rel_d   = rel_q & ~dom_bit(LAST_DOM);
          cnt_d   = OFF_LD;
        end
      end
      DN_RST: begin
        if (cnt_q == 4'd0) begin
          state_d  = DN_OFF;
          clk_en_d = clk_en_q & ~dom_bit(dom_q);
          cnt_d    = 4'd0;
        end
      end
      DN_OFF: begin
        // Single-cycle gap between gating one clock and resetting the next.
        if (dom_q == 3'd0) begin
          state_d = OFF;
          cnt_d   = 4'd0;
        end else begin
          state_d = DN_RST;
          dom_d   = dom_q - 3'd1;
          rel_d   = rel_q & ~dom_bit(dom_q - 3'd1);
          cnt_d   = OFF_LD;
        end
      end
      default: begin
        state_d  = OFF;
        dom_d    = 3'd0;
        clk_en_d = '0;
        rel_d    = '0;
        cnt_d    = 4'd0;
      end
    endcase

    busy_d     = (state_d != OFF) && (state_d != ON);
    all_up_d   = (state_d == ON);
    all_down_d = (state_d == OFF);
  end

  // State and registered outputs; reset forces the all-off condition at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= OFF;
      cnt_q      <= 4'd0;
      dom_q      <= 3'd0;
      clk_en_q   <= '0;
      rel_q      <= '0;
      busy_q     <= 1'b0;
      all_up_q   <= 1'b0;
      all_down_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dom_q      <= dom_d;
      clk_en_q   <= clk_en_d;
      rel_q      <= rel_d;
      busy_q     <= busy_d;
      all_up_q   <= all_up_d;
      all_down_q <= all_down_d;
    end
  end

  assign clk_en_o      = clk_en_q;
  assign release_rst_o = rel_q;
  assign cur_dom_o     = dom_q;
  assign busy_o        = busy_q;
  assign all_up_o      = all_up_q;
  assign all_down_o    = all_down_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// tb/tb_reset_seq_ctrl.sv - scoreboard bench for reset_seq_ctrl, default and minimal configs
module tb_reset_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_up_req = 1'b0, a_dn_req = 1'b0;
  logic       b_up_req = 1'b0, b_dn_req = 1'b0;
  logic [3:0] a_ce, a_rel;
  logic [2:0] a_dom, b_dom;
  logic       a_busy, a_all_up, a_all_dn;
  logic [0:0] b_ce, b_rel;
  logic       b_busy, b_all_up, b_all_dn;

  int edge_n = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] ce;
    logic [3:0] rel;
    logic [2:0] dom;
    logic       busy;
    logic       up;
    logic       dn;
    string      nm;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  reset_seq_ctrl u_a (
    .clk(clk), .reset(reset), .up_req_i(a_up_req), .down_req_i(a_dn_req),
    .clk_en_o(a_ce), .release_rst_o(a_rel), .cur_dom_o(a_dom),
    .busy_o(a_busy), .all_up_o(a_all_up), .all_down_o(a_all_dn)
  );

  reset_seq_ctrl #(.N_DOM(1), .PRE_CYC(1), .POST_CYC(1), .OFF_CYC(1)) u_b (
    .clk(clk), .reset(reset), .up_req_i(b_up_req), .down_req_i(b_dn_req),
    .clk_en_o(b_ce), .release_rst_o(b_rel), .cur_dom_o(b_dom),
    .busy_o(b_busy), .all_up_o(b_all_up), .all_down_o(b_all_dn)
  );

  task automatic check_entry(input string tag, input exp_t e, input logic [3:0] ce,
                             input logic [3:0] rel, input logic [2:0] dom,
                             input logic busy, input logic up, input logic dn);
    checks++;
    if (e.cyc != edge_n || ce !== e.ce || rel !== e.rel || dom !== e.dom ||
        busy !== e.busy || up !== e.up || dn !== e.dn) begin
      errors++;
      $display("FAIL %s.%s cyc=%0d/%0d got ce=%b rel=%b dom=%0d busy=%b up=%b dn=%b need ce=%b rel=%b dom=%0d busy=%b up=%b dn=%b",
               tag, e.nm, edge_n, e.cyc, ce, rel, dom, busy, up, dn,
               e.ce, e.rel, e.dom, e.busy, e.up, e.dn);
    end
  endtask

  // Monitors: compare whatever the scoreboard expects for the current cycle.
  always @(negedge clk) begin
    while (qa.size() > 0 && qa[0].cyc <= edge_n) begin
      ea = qa.pop_front();
      check_entry("a", ea, a_ce, a_rel, a_dom, a_busy, a_all_up, a_all_dn);
    end
  end

  always @(negedge clk) begin
    while (qb.size() > 0 && qb[0].cyc <= edge_n) begin
      eb = qb.pop_front();
      check_entry("b", eb, {3'b000, b_ce}, {3'b000, b_rel}, b_dom, b_busy, b_all_up, b_all_dn);
    end
  end

  // Structural invariants, every cycle, both instances.
  always @(negedge clk) begin
    checks++;
    if ((a_rel & ~a_ce) != 4'd0 || (a_rel & (a_rel + 4'd1)) != 4'd0) begin
      errors++;
      $display("FAIL inv_a cyc=%0d got ce=%b rel=%b need rel subset of ce and contiguous from bit0",
               edge_n, a_ce, a_rel);
    end
    checks++;
    if ((b_rel & ~b_ce) != 1'b0) begin
      errors++;
      $display("FAIL inv_b cyc=%0d got ce=%b rel=%b need rel subset of ce", edge_n, b_ce, b_rel);
    end
  end

  task automatic pa(input int cyc, input logic [3:0] ce, input logic [3:0] rel,
                    input logic [2:0] dom, input logic busy, input logic up,
                    input logic dn, input string nm);
    exp_t e;
    e.cyc = cyc; e.ce = ce; e.rel = rel; e.dom = dom;
    e.busy = busy; e.up = up; e.dn = dn; e.nm = nm;
    qa.push_back(e);
  endtask

  task automatic pb(input int cyc, input logic ce, input logic rel, input logic busy,
                    input logic up, input logic dn, input string nm);
    exp_t e;
    e.cyc = cyc; e.ce = {3'b000, ce}; e.rel = {3'b000, rel}; e.dom = 3'd0;
    e.busy = busy; e.up = up; e.dn = dn; e.nm = nm;
    qb.push_back(e);
  endtask

  // Hand-derived power-up timeline (defaults) for a request seen in cycle k.
  task automatic push_up(input int k, input int lim);
    if (lim >= 0)  pa(k,      4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, "pu_idle");
    if (lim >= 1)  pa(k + 1,  4'b0001, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, "pu_ce0");
    if (lim >= 4)  pa(k + 4,  4'b0001, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, "pu_pre_end");
    if (lim >= 5)  pa(k + 5,  4'b0001, 4'b0001, 3'd0, 1'b1, 1'b0, 1'b0, "pu_rel0");
    if (lim >= 7)  pa(k + 7,  4'b0011, 4'b0001, 3'd1, 1'b1, 1'b0, 1'b0, "pu_ce1");
    if (lim >= 11) pa(k + 11, 4'b0011, 4'b0011, 3'd1, 1'b1, 1'b0, 1'b0, "pu_rel1");
    if (lim >= 13) pa(k + 13, 4'b0111, 4'b0011, 3'd2, 1'b1, 1'b0, 1'b0, "pu_ce2");
    if (lim >= 19) pa(k + 19, 4'b1111, 4'b0111, 3'd3, 1'b1, 1'b0, 1'b0, "pu_ce3");
    if (lim >= 23) pa(k + 23, 4'b1111, 4'b1111, 3'd3, 1'b1, 1'b0, 1'b0, "pu_rel3");
    if (lim >= 24) pa(k + 24, 4'b1111, 4'b1111, 3'd3, 1'b1, 1'b0, 1'b0, "pu_post_end");
    if (lim >= 25) pa(k + 25, 4'b1111, 4'b1111, 3'd3, 1'b0, 1'b1, 1'b0, "pu_on");
    if (lim >= 28) pa(k + 28, 4'b1111, 4'b1111, 3'd3, 1'b0, 1'b1, 1'b0, "pu_on_hold");
  endtask

  // Hand-derived power-down timeline (defaults) for a request seen in cycle m.
  task automatic push_dn(input int m, input int lim);
    if (lim >= 0)  pa(m,      4'b1111, 4'b1111, 3'd3, 1'b0, 1'b1, 1'b0, "pd_on");
    if (lim >= 1)  pa(m + 1,  4'b1111, 4'b0111, 3'd3, 1'b1, 1'b0, 1'b0, "pd_rel3");
    if (lim >= 3)  pa(m + 3,  4'b1111, 4'b0111, 3'd3, 1'b1, 1'b0, 1'b0, "pd_rst_end");
    if (lim >= 4)  pa(m + 4,  4'b0111, 4'b0111, 3'd3, 1'b1, 1'b0, 1'b0, "pd_ce3");
    if (lim >= 5)  pa(m + 5,  4'b0111, 4'b0011, 3'd2, 1'b1, 1'b0, 1'b0, "pd_rel2");
    if (lim >= 8)  pa(m + 8,  4'b0011, 4'b0011, 3'd2, 1'b1, 1'b0, 1'b0, "pd_ce2");
    if (lim >= 9)  pa(m + 9,  4'b0011, 4'b0001, 3'd1, 1'b1, 1'b0, 1'b0, "pd_rel1");
    if (lim >= 12) pa(m + 12, 4'b0001, 4'b0001, 3'd1, 1'b1, 1'b0, 1'b0, "pd_ce1");
    if (lim >= 13) pa(m + 13, 4'b0001, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, "pd_rel0");
    if (lim >= 16) pa(m + 16, 4'b0000, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, "pd_ce0");
    if (lim >= 17) pa(m + 17, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, "pd_off");
    if (lim >= 20) pa(m + 20, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, "pd_off_hold");
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (qa.size() > 0 || qb.size() > 0); i++) step(1);
    if (qa.size() > 0 || qb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d need 0", qa.size() + qb.size());
    end
  endtask

  task automatic hold_off_a(input int from, input int n, input string nm);
    for (int i = 1; i <= n; i++)
      pa(from + i, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, nm);
  endtask

  initial begin
    int k;
    int m;

    // Reset state, then idle in OFF with no request.
    step(2);
    pa(edge_n, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, "rst_init");
    pb(edge_n, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst_init");
    step(1);
    reset = 1'b0;
    hold_off_a(edge_n, 3, "off_idle");
    step(4);
    drain();

    // Clean power-up.
    k = edge_n; a_up_req = 1'b1; push_up(k, 28);
    step(1); a_up_req = 1'b0;
    step(29);
    drain();

    // up_req in ON is ignored.
    k = edge_n; a_up_req = 1'b1;
    pa(k + 1, 4'b1111, 4'b1111, 3'd3, 1'b0, 1'b1, 1'b0, "on_up_ign");
    pa(k + 3, 4'b1111, 4'b1111, 3'd3, 1'b0, 1'b1, 1'b0, "on_up_ign2");
    step(1); a_up_req = 1'b0;
    step(3);
    drain();

    // Clean power-down.
    m = edge_n; a_dn_req = 1'b1; push_dn(m, 20);
    step(1); a_dn_req = 1'b0;
    step(21);
    drain();

    // down_req in OFF is ignored.
    k = edge_n; a_dn_req = 1'b1;
    hold_off_a(k, 3, "off_dn_ign");
    step(1); a_dn_req = 1'b0;
    step(3);
    drain();

    // Power-up with a down_req pulse while busy: no effect, no queuing.
    k = edge_n; a_up_req = 1'b1; push_up(k, 28);
    step(1); a_up_req = 1'b0;
    step(9); a_dn_req = 1'b1;
    step(1); a_dn_req = 1'b0;
    step(19);
    drain();

    // Both requests in ON: power-down only.
    m = edge_n; a_up_req = 1'b1; a_dn_req = 1'b1; push_dn(m, 20);
    step(1); a_up_req = 1'b0; a_dn_req = 1'b0;
    step(21);
    drain();

    // Both requests in OFF: power-up, then reset mid-sequence.
    k = edge_n; a_up_req = 1'b1; a_dn_req = 1'b1; push_up(k, 11);
    step(1); a_up_req = 1'b0; a_dn_req = 1'b0;
    step(11);
    reset = 1'b1;
    pa(k + 12, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, "rst_mid_up");
    step(2);
    reset = 1'b0;
    hold_off_a(edge_n, 4, "rst_up_hold");
    step(5);
    drain();

    // Power-up, power-down, reset during the first DN_RST.
    k = edge_n; a_up_req = 1'b1; push_up(k, 25);
    step(1); a_up_req = 1'b0;
    step(27);
    drain();
    m = edge_n; a_dn_req = 1'b1; push_dn(m, 2);
    step(1); a_dn_req = 1'b0;
    step(1);
    reset = 1'b1;
    pa(m + 2, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, "rst_mid_dn");
    step(2);
    reset = 1'b0;
    hold_off_a(edge_n, 4, "rst_dn_hold");
    step(5);
    drain();

    // Minimal configuration: one domain, one-cycle dwells.
    k = edge_n; b_up_req = 1'b1;
    pb(k,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "b_idle");
    pb(k + 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "b_ce0");
    pb(k + 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "b_rel0");
    pb(k + 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "b_on");
    step(1); b_up_req = 1'b0;
    step(4);
    drain();
    m = edge_n; b_dn_req = 1'b1; b_up_req = 1'b1;
    pb(m + 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "b_rst0");
    pb(m + 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "b_ce0_off");
    pb(m + 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "b_off");
    step(1); b_dn_req = 1'b0; b_up_req = 1'b0;
    step(4);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d need finish", edge_n);
    $fatal(1);
  end

endmodule
